imem_loader: RTL and testbench

Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes each word through a single-cycle write port into consecutive word-aligned instruction addresses, indexed the same way as the fetch path (byte address, word select = addr[31:2]). Holds the core in stall (`cpu_hold`) from reset until a load completes, so fetch never sees a partially written program.

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: assembles little-endian words and writes them out.
// Optional trailing checksum check enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StCheck,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] count_sat;
    logic        hs;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
    logic [31:0] expect_q, expect_d;
    logic        err_q, err_d;
`endif

    assign count_sat = ({16'd0, word_count} > DEPTH) ? 16'(DEPTH) : word_count;

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        expect_d    = expect_q;
        err_d       = err_q;
`endif
        // All handshake and status outputs decode straight from the registered state.
        rx_ready = (state_q == StRecv) || (state_q == StCheck);
        mem_we   = (state_q == StWrite);
        busy     = (state_q == StRecv) || (state_q == StWrite) || (state_q == StCheck);
        done     = (state_q == StDone);
        cpu_hold = (state_q != StDone);
        hs       = rx_valid && rx_ready;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    remaining_d = count_sat;
                    addr_d      = BASE_ADDR;
                    byte_idx_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = 32'd0;
                    expect_d    = 32'd0;
                    err_d       = 1'b0;
                    state_d     = (count_sat == 16'd0) ? StCheck : StRecv;
`else
                    state_d     = (count_sat == 16'd0) ? StDone : StRecv;
`endif
                end
            end
            StRecv: begin
                if (hs) begin
                    wdata_d[8*byte_idx_q +: 8] = rx_data;
                    byte_idx_d                 = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d      = addr_q + 32'd4;
                remaining_d = remaining_q - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d      = csum_q ^ wdata_q;
                state_d     = (remaining_q == 16'd1) ? StCheck : StRecv;
`else
                state_d     = (remaining_q == 16'd1) ? StDone : StRecv;
`endif
            end
            StCheck: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (hs) begin
                    expect_d[8*byte_idx_q +: 8] = rx_data;
                    byte_idx_d                  = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        err_d   = ({rx_data, expect_q[23:0]} != csum_q);
                        state_d = StDone;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_idx_q  <= 2'd0;
            remaining_q <= 16'd0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 32'd0;
            expect_q    <= 32'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            expect_q    <= expect_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, corner sequences and random loads
// checked against a word-list reference model.
module tb_imem_loader;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, rx_valid, rx_ready, mem_we, cpu_hold, busy, done, err;
    logic [15:0] word_count;
    logic [7:0]  rx_data;
    logic [31:0] mem_addr, mem_wdata;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int start_n, done_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Pulses start, then offers bytes; mode 0 back-to-back, 1 every other cycle, 2 random gaps.
    task automatic feed(input logic [15:0] wc, input logic [7:0] bytes[$], input int mode,
                        input bit noise);
        int i;
        int g;
        bit v, hs;
        @(negedge clk);
        start      = 1'b1;
        word_count = wc;
        start_n    = cyc;
        i = 0;
        g = 0;
        while (i < bytes.size() && g < 4000) begin
            @(negedge clk);
            start = 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       v = g[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            rx_valid = v;
            rx_data  = v ? bytes[i] : 8'($urandom);
            if (noise && $urandom_range(0, 5) == 0) start = 1'b1;
            hs = v && rx_ready;
            @(posedge clk);
            if (hs) i++;
            g++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        if (i < bytes.size()) check("feed_timeout_bytes_accepted", 32'(i), 32'(bytes.size()));
    endtask

    // Reference model: words land at BASE+4i in order; checksum is the XOR of all words.
    task automatic load_words(input string tag, input logic [15:0] wc, input logic [31:0] words[$],
                              input int mode, input bit noise, input bit bad);
        logic [7:0]  b[$];
        logic [31:0] x, sent;
        int          g;
        x = 32'd0;
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) b.push_back(words[i][8*k +: 8]);
            x ^= words[i];
        end
        sent = bad ? ((x != 32'd0) ? 32'd0 : 32'd1) : x;
        if (CSUM_ON) for (int k = 0; k < 4; k++) b.push_back(sent[8*k +: 8]);
        clear_writes();
        feed(wc, b, mode, noise);
        g = 0;
        while (done !== 1'b1 && g < 64) begin
            @(negedge clk);
            g++;
        end
        done_n = cyc;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(bad & CSUM_ON));
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(words.size()));
        for (int i = 0; i < words.size() && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], BASE + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], words[i]);
        end
    endtask

    typedef struct {
        logic [15:0] wc;
        logic [31:0] w0;
        logic [31:0] w1;
        int          mode;
        int          off0;
        int          off1;
        int          offd;
    } vec_t;

    vec_t        tbl[2];
    logic [31:0] wq[$];
    logic [7:0]  bq[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'd2, 32'h00100093, 32'h00200113, 0, 5, 10, 11};
        tbl[1] = '{16'd2, 32'h00100093, 32'h00200113, 1, 9, 17, 18};

        rst = 1'b1; start = 1'b0; word_count = 16'd0; rx_data = 8'd0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        for (int t = 0; t < 2; t++) begin
            wq.delete();
            wq.push_back(tbl[t].w0);
            wq.push_back(tbl[t].w1);
            load_words($sformatf("vec%0d", t), tbl[t].wc, wq, tbl[t].mode, 1'b0, 1'b0);
            if (wr_cyc.size() == 2) begin
                check($sformatf("vec%0d_wr0_cycle", t), 32'(wr_cyc[0] - start_n), 32'(tbl[t].off0));
                check($sformatf("vec%0d_wr1_cycle", t), 32'(wr_cyc[1] - start_n), 32'(tbl[t].off1));
            end
`ifndef IMEM_LOADER_CHECKSUM_EN
            check($sformatf("vec%0d_done_cycle", t), 32'(done_n - start_n), 32'(tbl[t].offd));
`endif
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        wq.delete();
        wq.push_back(32'h00100093);
        wq.push_back(32'h00200113);
        load_words("csum_bad", 16'd2, wq, 0, 1'b0, 1'b1);
`endif

        // Oversized count saturates to DEPTH; further bytes must never be accepted.
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        load_words("sat", 16'd100, wq, 0, 1'b0, 1'b0);
        if (wr_addr.size() > 0) check("sat_last_addr", wr_addr[wr_addr.size() - 1], 32'h000000FC);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            check($sformatf("sat_extra_rx_ready%0d", i), 32'(rx_ready), 32'd0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("sat_no_extra_writes", 32'(wr_addr.size()), 32'(DEPTH));

        // Reset in the middle of the second word of a 3-word load.
        clear_writes();
        bq.delete();
        for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
        feed(16'd3, bq, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_mem_addr", mem_addr, BASE);
        check("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        load_words("postrst", 16'd1, wq, 0, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int unsigned wc;
            wc = (r == 5) ? 0 : $urandom_range(0, 7);
            wq.delete();
            for (int i = 0; i < int'(wc); i++) wq.push_back($urandom);
            load_words($sformatf("rnd%0d", r), 16'(wc), wq, 2, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
